// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//   Types shared by the multicycle CPU memory-access path.
//   mem_cmd_t   : command presented on the memory port (NONE/READ/WRITE).
//   mau_state_t : sequencer states of mem_access_unit.
//   cmd_for_state() : maps a sequencer state to the command it drives.
// ---------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10
  } mem_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_STORE,
    ST_ERR
  } mau_state_t;

  // The memory command is a pure function of the state (Moore output).
  function automatic mem_cmd_t cmd_for_state(mau_state_t s);
    case (s)
      ST_FETCH, ST_LOAD: return MEM_READ;
      ST_STORE:          return MEM_WRITE;
      default:           return MEM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// ---------------------------------------------------------------------------
// mem_access_unit_if
//   Memory port between the access sequencer (master) and memory (slave).
//   mem_cmd    : master -> slave, NONE/READ/WRITE
//   mem_addr   : master -> slave, word address
//   write_data : master -> slave, store data
//   mem_ready  : slave -> master, completes the current command
//   read_data  : slave -> master, read data (valid with mem_ready)
// ---------------------------------------------------------------------------
interface mem_access_unit_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);

  mem_cmd_t            mem_cmd;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   write_data;
  logic                mem_ready;
  logic [DATA_W-1:0]   read_data;

  modport master (
    output mem_cmd, mem_addr, write_data,
    input  mem_ready, read_data
  );

  modport slave (
    input  mem_cmd, mem_addr, write_data,
    output mem_ready, read_data
  );

endinterface

// File: rtl/mau_wait_timer.sv
// ---------------------------------------------------------------------------
// mau_wait_timer
//   Counts wait cycles of a memory transaction and flags a timeout.
//   clk        : rising-edge clock
//   reset      : asynchronous active-low reset
//   clear      : restart the count (transaction accepted)
//   wait_cycle : current cycle is busy and memory did not answer
//   timeout    : this wait cycle is the MAX_WAIT-th one
// ---------------------------------------------------------------------------
module mau_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic wait_cycle,
  output logic timeout
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (wait_cycle) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  // Flag on the cycle that would bring the count to MAX_WAIT, so the
  // sequencer leaves for ERR on the same edge instead of one cycle later.
  assign timeout = wait_cycle && (count_reg == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//   Memory-access sequencer of the multicycle CPU. Owns PC, data address
//   (DA), instruction register and memory-data register; runs fetch, load
//   and store transactions with wait states and a timeout.
//   clk, reset          : clock, asynchronous active-low reset
//   reset_pc            : PC <- RESET_PC, abort to IDLE (any state)
//   fetch_req/ld_req/st_req : start a transaction (IDLE only)
//   load_addr, addr_in  : DA <- addr_in (IDLE only)
//   wr_in               : store data, latched on acceptance
//   br_taken, br_off    : PC <- PC + sext(br_off) (IDLE only)
//   clr_err             : clear err, leave ERR
//   mem                 : memory port (master side)
//   ins, mdata, pc      : architectural registers
//   busy, done, err     : status (done is a one-cycle pulse, err sticky)
// ---------------------------------------------------------------------------
module mem_access_unit
  import cpu_pkg::*;
#(
  parameter int          ADDR_W   = 9,
  parameter int          DATA_W   = 16,
  parameter int          OFF_W    = 8,
  parameter int unsigned RESET_PC = 0,
  parameter int          MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                reset_pc,
  input  logic                fetch_req,
  input  logic                ld_req,
  input  logic                st_req,
  input  logic                load_addr,
  input  logic [DATA_W-1:0]   addr_in,
  input  logic [DATA_W-1:0]   wr_in,
  input  logic                br_taken,
  input  logic [OFF_W-1:0]    br_off,
  input  logic                clr_err,
  mem_access_unit_if.master   mem,
  output logic [DATA_W-1:0]   ins,
  output logic [DATA_W-1:0]   mdata,
  output logic [ADDR_W-1:0]   pc,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

  mau_state_t          state_reg, state_next;
  logic [ADDR_W-1:0]   pc_reg, pc_next;
  logic [ADDR_W-1:0]   da_reg, da_next;
  logic [DATA_W-1:0]   ins_reg, ins_next;
  logic [DATA_W-1:0]   mdata_reg, mdata_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic                done_reg, done_next;
  logic                err_reg, err_next;

  logic                in_xfer;
  logic                accept;
  logic                wait_cycle;
  logic                timeout;
  logic [ADDR_W-1:0]   br_ext;

  // Only the low ADDR_W bits of the datapath value form an address.
  if (DATA_W > ADDR_W) begin : g_addr_trunc
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_in[DATA_W-1:ADDR_W];
  end

  assign in_xfer    = (state_reg == ST_FETCH) || (state_reg == ST_LOAD) ||
                      (state_reg == ST_STORE);
  assign accept     = (state_reg == ST_IDLE) && !reset_pc && !br_taken &&
                      (fetch_req || ld_req || st_req);
  assign wait_cycle = in_xfer && !mem.mem_ready;
  // Sign-extend (or wrap) the offset to the PC width; the add then wraps.
  assign br_ext     = ADDR_W'(signed'(br_off));

  mau_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .clear      (accept),
    .wait_cycle (wait_cycle),
    .timeout    (timeout)
  );

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    da_next    = da_reg;
    ins_next   = ins_reg;
    mdata_next = mdata_reg;
    wdata_next = wdata_reg;
    done_next  = 1'b0;
    err_next   = err_reg;

    case (state_reg)
      ST_IDLE: begin
        // DA load is independent of the request priority chain.
        if (load_addr) da_next = addr_in[ADDR_W-1:0];
        if (reset_pc) begin
          pc_next = PC_INIT;
        end else if (br_taken) begin
          pc_next = pc_reg + br_ext;
        end else if (fetch_req) begin
          state_next = ST_FETCH;
        end else if (ld_req) begin
          state_next = ST_LOAD;
        end else if (st_req) begin
          state_next = ST_STORE;
          wdata_next = wr_in;
        end
      end
      ST_FETCH, ST_LOAD, ST_STORE: begin
        if (reset_pc) begin
          pc_next    = PC_INIT;
          state_next = ST_IDLE;
        end else if (mem.mem_ready) begin
          if (state_reg == ST_FETCH) begin
            ins_next = mem.read_data;
            pc_next  = pc_reg + ADDR_W'(1);
          end else if (state_reg == ST_LOAD) begin
            mdata_next = mem.read_data;
          end
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end else if (timeout) begin
          state_next = ST_ERR;
          err_next   = 1'b1;
        end
      end
      ST_ERR: begin
        if (reset_pc) begin
          pc_next    = PC_INIT;
          state_next = ST_IDLE;
        end else if (clr_err) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // A timeout raised on this edge wins over a simultaneous clear.
    if (clr_err && (state_next != ST_ERR)) err_next = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      pc_reg    <= PC_INIT;
      da_reg    <= '0;
      ins_reg   <= '0;
      mdata_reg <= '0;
      wdata_reg <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      da_reg    <= da_next;
      ins_reg   <= ins_next;
      mdata_reg <= mdata_next;
      wdata_reg <= wdata_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  assign mem.mem_cmd    = cmd_for_state(state_reg);
  assign mem.mem_addr   = ((state_reg == ST_LOAD) || (state_reg == ST_STORE)) ?
                          da_reg : pc_reg;
  assign mem.write_data = wdata_reg;

  assign ins   = ins_reg;
  assign mdata = mdata_reg;
  assign pc    = pc_reg;
  assign busy  = (state_reg != ST_IDLE);
  assign done  = done_reg;
  assign err   = err_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
//   Self-checking bench: reset values, a table of IDLE-state PC operations,
//   hand-written multi-cycle sequences, then randomized traffic compared
//   every cycle against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;
  import cpu_pkg::*;

  localparam int ADDR_W   = 9;
  localparam int DATA_W   = 16;
  localparam int OFF_W    = 8;
  localparam int RESET_PC = 0;
  localparam int MAX_WAIT = 15;
  localparam int AMOD     = 1 << ADDR_W;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                reset_pc = 1'b0, fetch_req = 1'b0, ld_req = 1'b0, st_req = 1'b0;
  logic                load_addr = 1'b0, br_taken = 1'b0, clr_err = 1'b0;
  logic [DATA_W-1:0]   addr_in = '0, wr_in = '0;
  logic [OFF_W-1:0]    br_off = '0;
  logic [DATA_W-1:0]   ins, mdata;
  logic [ADDR_W-1:0]   pc;
  logic                busy, done, err;

  mem_access_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

  mem_access_unit #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OFF_W(OFF_W),
    .RESET_PC(RESET_PC), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .reset(reset), .reset_pc(reset_pc), .fetch_req(fetch_req),
    .ld_req(ld_req), .st_req(st_req), .load_addr(load_addr), .addr_in(addr_in),
    .wr_in(wr_in), .br_taken(br_taken), .br_off(br_off), .clr_err(clr_err),
    .mem(mem_bus), .ins(ins), .mdata(mdata), .pc(pc), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    reset_pc = 0; fetch_req = 0; ld_req = 0; st_req = 0;
    load_addr = 0; br_taken = 0; clr_err = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " mem_cmd"},    32'(mem_bus.mem_cmd), 32'(MEM_NONE));
    chk({tag, " mem_addr"},   32'(mem_bus.mem_addr), RESET_PC);
    chk({tag, " write_data"}, 32'(mem_bus.write_data), 0);
    chk({tag, " ins"},        32'(ins), 0);
    chk({tag, " mdata"},      32'(mdata), 0);
    chk({tag, " pc"},         32'(pc), RESET_PC);
    chk({tag, " busy"},       32'(busy), 0);
    chk({tag, " done"},       32'(done), 0);
    chk({tag, " err"},        32'(err), 0);
  endtask

  // ---------------- table of IDLE-state PC operations ----------------
  typedef struct {
    logic              rst_pc;
    logic              br;
    logic [OFF_W-1:0]  off;
    logic              fetch;
    logic [ADDR_W-1:0] exp_pc;
    logic              exp_busy;
  } pc_vec_t;

  pc_vec_t pc_tab[10];

  // ---------------- reference model (transaction level) ----------------
  localparam int K_IDLE = 0, K_FETCH = 1, K_LOAD = 2, K_STORE = 3, K_ERR = 4;
  int m_kind, m_pc, m_da, m_ins, m_mdata, m_wd, m_done, m_err, m_wait, m_txn;

  task automatic model_reset();
    m_kind = K_IDLE; m_pc = RESET_PC; m_da = 0; m_ins = 0; m_mdata = 0;
    m_wd = 0; m_done = 0; m_err = 0; m_wait = 0; m_txn = 0;
  endtask

  // Advance the model across one clock edge using the current inputs.
  task automatic model_step();
    int off;
    bit timed_out;
    timed_out = 0;
    m_done = 0;
    if (m_kind == K_IDLE) begin
      if (load_addr) m_da = int'(addr_in) % AMOD;
      if (reset_pc) m_pc = RESET_PC;
      else if (br_taken) begin
        off = int'(br_off);
        if (off >= (1 << (OFF_W - 1))) off -= (1 << OFF_W);
        m_pc = (m_pc + off + AMOD) % AMOD;
      end
      else if (fetch_req) begin m_kind = K_FETCH; m_wait = 0; end
      else if (ld_req)    begin m_kind = K_LOAD;  m_wait = 0; end
      else if (st_req)    begin m_kind = K_STORE; m_wait = 0; m_wd = int'(wr_in); end
    end else if (m_kind == K_ERR) begin
      if (reset_pc) begin m_pc = RESET_PC; m_kind = K_IDLE; end
      if (clr_err) m_kind = K_IDLE;
    end else begin
      if (reset_pc) begin
        m_pc = RESET_PC; m_kind = K_IDLE;
      end else if (mem_bus.mem_ready) begin
        m_txn++;
        case (m_kind)
          K_FETCH: begin
            $display("txn %0d: fetch pc=0x%0h ins=0x%0h", m_txn, m_pc, mem_bus.read_data);
            m_ins = int'(mem_bus.read_data);
            m_pc = (m_pc + 1) % AMOD;
          end
          K_LOAD: begin
            $display("txn %0d: load  da=0x%0h data=0x%0h", m_txn, m_da, mem_bus.read_data);
            m_mdata = int'(mem_bus.read_data);
          end
          default: $display("txn %0d: store da=0x%0h data=0x%0h", m_txn, m_da, m_wd);
        endcase
        m_done = 1; m_kind = K_IDLE;
      end else begin
        m_wait++;
        if (m_wait == MAX_WAIT) begin
          m_txn++;
          $display("txn %0d: timeout after %0d wait cycles", m_txn, m_wait);
          m_kind = K_ERR; m_err = 1; timed_out = 1;
        end
      end
    end
    if (clr_err && !timed_out) m_err = 0;
  endtask

  task automatic model_compare(input int cyc);
    int exp_cmd, exp_addr;
    string t;
    exp_cmd  = (m_kind == K_FETCH || m_kind == K_LOAD) ? 1 : (m_kind == K_STORE) ? 2 : 0;
    exp_addr = (m_kind == K_LOAD || m_kind == K_STORE) ? m_da : m_pc;
    t = $sformatf("rand[%0d]", cyc);
    chk({t, " mem_cmd"},    32'(mem_bus.mem_cmd), exp_cmd);
    chk({t, " mem_addr"},   32'(mem_bus.mem_addr), exp_addr);
    chk({t, " write_data"}, 32'(mem_bus.write_data), m_wd);
    chk({t, " ins"},        32'(ins), m_ins);
    chk({t, " mdata"},      32'(mdata), m_mdata);
    chk({t, " pc"},         32'(pc), m_pc);
    chk({t, " busy"},       32'(busy), (m_kind != K_IDLE) ? 1 : 0);
    chk({t, " done"},       32'(done), m_done);
    chk({t, " err"},        32'(err), m_err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pcts[4];
    pcts = '{80, 40, 0, 60};

    pc_tab[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 9'h000, 1'b0};
    pc_tab[1] = '{1'b0, 1'b1, 8'h05, 1'b0, 9'h005, 1'b0};
    pc_tab[2] = '{1'b0, 1'b1, 8'hFE, 1'b0, 9'h003, 1'b0};
    pc_tab[3] = '{1'b0, 1'b1, 8'h80, 1'b0, 9'h183, 1'b0};
    pc_tab[4] = '{1'b0, 1'b1, 8'h7F, 1'b0, 9'h002, 1'b0};
    pc_tab[5] = '{1'b1, 1'b1, 8'h10, 1'b0, 9'h000, 1'b0};
    pc_tab[6] = '{1'b0, 1'b1, 8'hFF, 1'b0, 9'h1FF, 1'b0};
    pc_tab[7] = '{1'b0, 1'b1, 8'h01, 1'b0, 9'h000, 1'b0};
    pc_tab[8] = '{1'b0, 1'b1, 8'h02, 1'b1, 9'h002, 1'b0};
    pc_tab[9] = '{1'b0, 1'b0, 8'h55, 1'b0, 9'h002, 1'b0};

    mem_bus.mem_ready = 1'b0;
    mem_bus.read_data = '0;

    // ---- reset state ----
    tick(); tick();
    check_reset_outputs("reset");
    $display("seq reset: outputs checked while reset held");

    // ---- A: fetch with mem_ready tied high ----
    reset = 1'b1;
    fetch_req = 1; mem_bus.mem_ready = 1; mem_bus.read_data = 16'hBEEF;
    tick();
    fetch_req = 0;
    chk("A cmd c1",  32'(mem_bus.mem_cmd), 32'(MEM_READ));
    chk("A addr c1", 32'(mem_bus.mem_addr), 0);
    chk("A busy c1", 32'(busy), 1);
    chk("A done c1", 32'(done), 0);
    tick();
    chk("A ins c2",  32'(ins), 32'hBEEF);
    chk("A pc c2",   32'(pc), 1);
    chk("A done c2", 32'(done), 1);
    chk("A busy c2", 32'(busy), 0);
    chk("A cmd c2",  32'(mem_bus.mem_cmd), 32'(MEM_NONE));
    tick();
    chk("A done c3", 32'(done), 0);
    $display("seq A: fetch, zero wait states");

    // ---- B: load_addr then load with 3 wait cycles ----
    mem_bus.mem_ready = 0;
    load_addr = 1; addr_in = 16'h0123;
    tick();
    load_addr = 0; ld_req = 1; mem_bus.read_data = 16'h5A5A;
    tick();
    ld_req = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("B addr w%0d", i), 32'(mem_bus.mem_addr), 32'h123);
      chk($sformatf("B cmd w%0d", i),  32'(mem_bus.mem_cmd), 32'(MEM_READ));
      chk($sformatf("B done w%0d", i), 32'(done), 0);
      mem_bus.mem_ready = (i == 3);
      tick();
    end
    mem_bus.mem_ready = 0;
    chk("B mdata", 32'(mdata), 32'h5A5A);
    chk("B done",  32'(done), 1);
    chk("B busy",  32'(busy), 0);
    chk("B pc",    32'(pc), 1);
    $display("seq B: load with 3 wait cycles, latency 5");

    // ---- table: IDLE-state PC operations ----
    for (int v = 0; v < 10; v++) begin
      reset_pc = pc_tab[v].rst_pc; br_taken = pc_tab[v].br;
      br_off = pc_tab[v].off; fetch_req = pc_tab[v].fetch;
      tick();
      clear_inputs();
      chk($sformatf("tab[%0d] pc", v),   32'(pc), 32'(pc_tab[v].exp_pc));
      chk($sformatf("tab[%0d] addr", v), 32'(mem_bus.mem_addr), 32'(pc_tab[v].exp_pc));
      chk($sformatf("tab[%0d] busy", v), 32'(busy), 32'(pc_tab[v].exp_busy));
      $display("vec %0d: rst_pc=%0b br=%0b off=0x%0h -> pc=0x%0h", v,
               pc_tab[v].rst_pc, pc_tab[v].br, pc_tab[v].off, pc);
    end

    // ---- C: PC wraps on fetch at 0x1FF ----
    reset_pc = 1; tick(); reset_pc = 0;
    br_taken = 1; br_off = 8'hFF; tick(); br_taken = 0;
    chk("C pc pre", 32'(pc), 32'h1FF);
    fetch_req = 1; mem_bus.mem_ready = 1; mem_bus.read_data = 16'h1234;
    tick();
    fetch_req = 0;
    chk("C addr", 32'(mem_bus.mem_addr), 32'h1FF);
    tick();
    mem_bus.mem_ready = 0;
    chk("C pc wrap", 32'(pc), 0);
    chk("C ins",     32'(ins), 32'h1234);
    $display("seq C: fetch at 0x1FF wraps pc");

    // ---- D: store timeout, ERR ignores requests, clr_err exits ----
    st_req = 1; wr_in = 16'hCAFE; load_addr = 1; addr_in = 16'hFE42;
    tick();
    clear_inputs(); wr_in = 16'h1111;
    for (int i = 0; i < MAX_WAIT; i++) begin
      chk($sformatf("D busy w%0d", i),  32'(busy), 1);
      chk($sformatf("D err w%0d", i),   32'(err), 0);
      chk($sformatf("D done w%0d", i),  32'(done), 0);
      chk($sformatf("D cmd w%0d", i),   32'(mem_bus.mem_cmd), 32'(MEM_WRITE));
      chk($sformatf("D addr w%0d", i),  32'(mem_bus.mem_addr), 32'h042);
      chk($sformatf("D wdata w%0d", i), 32'(mem_bus.write_data), 32'hCAFE);
      tick();
    end
    chk("D err",      32'(err), 1);
    chk("D busy err", 32'(busy), 1);
    chk("D done err", 32'(done), 0);
    chk("D cmd err",  32'(mem_bus.mem_cmd), 32'(MEM_NONE));
    fetch_req = 1; ld_req = 1; br_taken = 1; br_off = 8'h04;
    tick();
    clear_inputs();
    chk("D ignore cmd",  32'(mem_bus.mem_cmd), 32'(MEM_NONE));
    chk("D ignore pc",   32'(pc), 0);
    chk("D ignore err",  32'(err), 1);
    clr_err = 1;
    tick();
    clr_err = 0;
    chk("D clr err",  32'(err), 0);
    chk("D clr busy", 32'(busy), 0);
    $display("seq D: store timeout after %0d wait cycles", MAX_WAIT);

    // ---- E: fetch and load together -> fetch only ----
    fetch_req = 1; ld_req = 1; mem_bus.mem_ready = 1; mem_bus.read_data = 16'h7777;
    tick();
    clear_inputs();
    chk("E addr", 32'(mem_bus.mem_addr), 0);
    tick();
    mem_bus.mem_ready = 0;
    chk("E ins",   32'(ins), 32'h7777);
    chk("E mdata", 32'(mdata), 32'h5A5A);
    chk("E pc",    32'(pc), 1);
    chk("E done",  32'(done), 1);
    $display("seq E: simultaneous fetch/load, fetch wins");

    // ---- F: reset_pc in the middle of a load ----
    ld_req = 1; mem_bus.read_data = 16'h9999;
    tick();
    ld_req = 0;
    tick(); tick();
    reset_pc = 1;
    tick();
    reset_pc = 0;
    chk("F busy",  32'(busy), 0);
    chk("F pc",    32'(pc), RESET_PC);
    chk("F mdata", 32'(mdata), 32'h5A5A);
    chk("F done",  32'(done), 0);
    tick();
    chk("F done later", 32'(done), 0);
    $display("seq F: reset_pc aborts load");

    // ---- G: asynchronous reset between edges during a store ----
    st_req = 1; wr_in = 16'hABCD;
    tick();
    st_req = 0;
    chk("G wdata", 32'(mem_bus.write_data), 32'hABCD);
    chk("G busy",  32'(busy), 1);
    #2 reset = 1'b0;
    #1 check_reset_outputs("G async");
    tick();
    reset = 1'b1;
    $display("seq G: async reset mid-store");

    // ---- randomized traffic against the reference model ----
    model_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      model_compare(cyc);
      if (n_fail > 60) break;
      reset_pc  = ($urandom_range(0, 99) < 2);
      br_taken  = ($urandom_range(0, 9) == 0);
      fetch_req = ($urandom_range(0, 2) == 0);
      ld_req    = ($urandom_range(0, 2) == 0);
      st_req    = ($urandom_range(0, 2) == 0);
      load_addr = ($urandom_range(0, 4) == 0);
      clr_err   = ($urandom_range(0, 19) == 0);
      addr_in   = 16'($urandom);
      wr_in     = 16'($urandom);
      br_off    = 8'($urandom);
      mem_bus.read_data = 16'($urandom);
      mem_bus.mem_ready = ($urandom_range(0, 99) < pcts[(cyc / 100) % 4]);
      model_step();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised memory-access sequencer for the multicycle CPU. Owns the program counter, data-address register, instruction register and memory-data register. Runs instruction fetch, load and store transactions on a memory port with a ready handshake, wait states and a timeout. Sits between the control FSM/datapath and the memory.

## Interface
Parameters:
- ADDR_W, 9, width of PC, data address and mem_addr
- DATA_W, 16, width of instruction/data words
- OFF_W, 8, width of signed branch offset
- RESET_PC, 0, PC value after reset or reset_pc
- MAX_WAIT, 15, wait cycles allowed before timeout (≥1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- reset_pc  in  1  sync: PC←RESET_PC, abort to IDLE
- fetch_req  in  1  start instruction fetch at PC
- ld_req  in  1  start load at data address
- st_req  in  1  start store of wr_in at data address
- load_addr  in  1  DA←addr_in[ADDR_W-1:0] (IDLE only)
- addr_in  in  DATA_W  datapath output
- wr_in  in  DATA_W  store data
- br_taken  in  1  PC←PC+sext(br_off) (IDLE only)
- br_off  in  OFF_W  signed offset
- clr_err  in  1  clear err, ERR→IDLE
- mem_ready  in  1  memory completes the current command
- read_data  in  DATA_W  memory read data
- mem_cmd  out  2  00 NONE, 01 READ, 10 WRITE
- mem_addr  out  ADDR_W  memory address
- write_data  out  DATA_W  store data to memory
- ins  out  DATA_W  instruction register
- mdata  out  DATA_W  load result register
- pc  out  ADDR_W  current PC
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  sticky timeout flag

## Operation
- States: IDLE, FETCH, LOAD, STORE, ERR.
- IDLE: request accepted on the edge where it is high; priority reset_pc > br_taken > fetch_req > ld_req > st_req. Lower-priority requests in the same cycle are dropped (the FSM must re-assert them). load_addr is independent and may coincide with br_taken or a request; it updates DA on that same edge. Any request then uses the new DA from the following cycle.
- FETCH: mem_cmd=READ, mem_addr=PC. On mem_ready: ins←read_data, PC←PC+1 (mod 2^ADDR_W), done=1 next cycle, →IDLE.
- LOAD: mem_cmd=READ, mem_addr=DA. On mem_ready: mdata←read_data, →IDLE with done.
- STORE: mem_cmd=WRITE, mem_addr=DA, write_data=wr_in latched at acceptance. On mem_ready: →IDLE with done.
- IDLE/ERR: mem_cmd=NONE, mem_addr=PC.
- Wait counter: cleared on acceptance, +1 each busy cycle without mem_ready. If MAX_WAIT is reached without ready: →ERR, err=1, no register update, no done.
- ERR: ignores all requests. clr_err→IDLE and err=0. reset_pc also exits.
- Branch arithmetic: br_off is sign-extended to ADDR_W; the sum wraps modulo 2^ADDR_W.
- reset_pc in any state: PC←RESET_PC, →IDLE, in-flight transaction discarded, err unchanged.
- br_taken/load_addr while busy: ignored.

## Timing
- Reset (async, reset=0): state IDLE, pc=RESET_PC, DA=0, ins=0, mdata=0, write_data=0, mem_cmd=NONE, mem_addr=RESET_PC, busy=0, done=0, err=0.
- Request at edge k → mem_cmd valid in cycle k+1. If mem_ready is high in cycle k+1, results register at edge k+2, done is high in cycle k+2, busy low in cycle k+2. Minimum latency 2 cycles; each wait cycle adds 1.
- done and mem_cmd are Moore outputs (registered state/flag); mem_ready is sampled only while busy.
- A new request may be accepted in the cycle done is high.

## Structure
- Shared package cpu_pkg: mem_cmd_t enum (MEM_NONE, MEM_READ, MEM_WRITE), mau_state_t enum.
- One sub-module, mau_wait_timer (counter + timeout compare, param MAX_WAIT).

## Test plan
- Reset release, fetch_req, mem_ready tied 1 → mem_cmd=01, mem_addr=0 in cycle 1; ins=read_data, pc=1, done pulse in cycle 2.
- load_addr with addr_in=0x0123, then ld_req, ready after 3 wait cycles → mem_addr=0x123 for 4 cycles; mdata captured; latency 5.
- pc=5, br_taken with br_off=0xFE → pc=3. pc=0x1FF, fetch → pc wraps to 0.
- st_req with mem_ready held 0, MAX_WAIT=15 → ERR after 15 cycles, err=1, no done. Requests ignored; clr_err → IDLE.
- fetch_req+ld_req same cycle → fetch only. reset_pc mid-LOAD → IDLE, pc=RESET_PC, mdata unchanged.
- Async reset asserted mid-STORE (between edges) → all outputs at reset values immediately.
